if_instruction_memory_sync: RTL and testbench

Parametrised, synchronous-read instruction memory for the IF stage of the MIPS32 pipeline. It returns the instruction word one cycle after the PC is presented. It supports pipeline stall and flush, and flags misaligned and out-of-range fetches. A streaming program-load port lets the bench or a boot loader rewrite memory at run time without re-elaboration.

---
 rtl/if_instruction_memory_sync.sv | 174 +++++++++++++++++
 tb/tb_if_instruction_memory_sync.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_instruction_memory_sync.sv
// IF-stage instruction memory: synchronous read with stall/flush/fault
// flags and a streaming program-load port for run-time rewrites.
//
// Ports:
//   Clk, Reset        - clock, synchronous active-high reset
//   PC_IF, Fetch_En   - fetch address and request
//   Stall_IF          - hold all fetch outputs
//   Flush_IF          - replace the word being produced with a NOP
//   Instruction_IF    - registered instruction word
//   Valid_IF          - Instruction_IF holds a fetched word
//   Fault_Misaligned  - fetched byte PC not word aligned
//   Fault_Range       - fetched word index >= DEPTH
//   Load_Start/Base   - open a load session at word index Load_Base
//   Load_Valid/Data   - one write beat
//   Load_Last         - closes the session on a valid beat
//   Load_Busy         - load session active
//   Load_Count        - words written in the current or last session
module if_instruction_memory_sync #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter bit BYTE_ADDR  = 1'b1
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [ADDR_WIDTH-1:0]    PC_IF,
   input  logic                     Fetch_En,
   input  logic                     Stall_IF,
   input  logic                     Flush_IF,
   output logic [DATA_WIDTH-1:0]    Instruction_IF,
   output logic                     Valid_IF,
   output logic                     Fault_Misaligned,
   output logic                     Fault_Range,
   input  logic                     Load_Start,
   input  logic [$clog2(DEPTH)-1:0] Load_Base,
   input  logic                     Load_Valid,
   input  logic [DATA_WIDTH-1:0]    Load_Data,
   input  logic                     Load_Last,
   output logic                     Load_Busy,
   output logic [$clog2(DEPTH):0]   Load_Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_LOAD = 1'b1
   } state_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_instr;
   logic                  r_valid;
   logic                  r_fmis;
   logic                  r_frng;
   logic [AW-1:0]         r_ptr;
   logic [CW-1:0]         r_cnt;

   state_t                w_state;
   logic [DATA_WIDTH-1:0] w_instr;
   logic                  w_valid;
   logic                  w_fmis;
   logic                  w_frng;
   logic [AW-1:0]         w_ptr;
   logic [CW-1:0]         w_cnt;

   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_mis;
   logic                  w_rng;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_wr;

   // Range check uses the full-width index so huge PCs never alias.
   always_comb begin
      w_idx = PC_IF;
      if (BYTE_ADDR)
         w_idx = {2'b00, PC_IF[ADDR_WIDTH-1:2]};
      w_mis   = BYTE_ADDR && (PC_IF[1:0] != 2'b00);
      w_rng   = (w_idx >= ADDR_WIDTH'(DEPTH));
      w_rdata = r_mem[w_idx[AW-1:0]];
   end

   assign w_wr = !Reset && (r_state == S_LOAD) && Load_Valid;

   always_comb begin
      w_state = r_state;
      w_instr = r_instr;
      w_valid = r_valid;
      w_fmis  = r_fmis;
      w_frng  = r_frng;
      w_ptr   = r_ptr;
      w_cnt   = r_cnt;
      unique case (r_state)
         S_RUN: begin
            if (Flush_IF) begin
               w_instr = '0;
               w_valid = 1'b0;
               w_fmis  = 1'b0;
               w_frng  = 1'b0;
            end else if (Stall_IF) begin
               w_valid = r_valid;
            end else if (Load_Start) begin
               w_state = S_LOAD;
               w_ptr   = Load_Base;
               w_cnt   = '0;
               w_instr = '0;
               w_valid = 1'b0;
               w_fmis  = 1'b0;
               w_frng  = 1'b0;
            end else if (Fetch_En) begin
               w_valid = 1'b1;
               w_fmis  = w_mis;
               w_frng  = w_rng;
               // Faulting fetches still flow down the pipe as a NOP.
               w_instr = (w_mis || w_rng) ? '0 : w_rdata;
            end else begin
               w_valid = 1'b0;
               w_fmis  = 1'b0;
               w_frng  = 1'b0;
            end
         end
         S_LOAD: begin
            w_instr = '0;
            w_valid = 1'b0;
            w_fmis  = 1'b0;
            w_frng  = 1'b0;
            if (Load_Valid) begin
               w_ptr = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
               if (r_cnt != CW'(DEPTH))
                  w_cnt = r_cnt + 1'b1;
               if (Load_Last)
                  w_state = S_RUN;
            end
         end
         default: w_state = S_RUN;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_RUN;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_fmis  <= 1'b0;
         r_frng  <= 1'b0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state;
         r_instr <= w_instr;
         r_valid <= w_valid;
         r_fmis  <= w_fmis;
         r_frng  <= w_frng;
         r_ptr   <= w_ptr;
         r_cnt   <= w_cnt;
      end
   end

   // Contents survive reset; only an accepted load beat writes.
   always_ff @(posedge Clk) begin
      if (w_wr)
         r_mem[r_ptr] <= Load_Data;
   end

   assign Instruction_IF   = r_instr;
   assign Valid_IF         = r_valid;
   assign Fault_Misaligned = r_fmis;
   assign Fault_Range      = r_frng;
   assign Load_Busy        = (r_state == S_LOAD);
   assign Load_Count       = r_cnt;

endmodule

// File: tb/tb_if_instruction_memory_sync.sv
// Directed bench for if_instruction_memory_sync with a behavioural
// model compared every cycle plus literal spot checks.
module tb_if_instruction_memory_sync;

   localparam int D = 1024;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] PC_IF;
   logic        Fetch_En, Stall_IF, Flush_IF;
   logic [31:0] Instruction_IF;
   logic        Valid_IF, Fault_Misaligned, Fault_Range;
   logic        Load_Start, Load_Valid, Load_Last;
   logic [9:0]  Load_Base;
   logic [31:0] Load_Data;
   logic        Load_Busy;
   logic [10:0] Load_Count;

   int tests = 0;
   int fails = 0;

   if_instruction_memory_sync #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(D), .BYTE_ADDR(1'b1)
   ) dut (
      .Clk(Clk), .Reset(Reset), .PC_IF(PC_IF), .Fetch_En(Fetch_En),
      .Stall_IF(Stall_IF), .Flush_IF(Flush_IF),
      .Instruction_IF(Instruction_IF), .Valid_IF(Valid_IF),
      .Fault_Misaligned(Fault_Misaligned), .Fault_Range(Fault_Range),
      .Load_Start(Load_Start), .Load_Base(Load_Base),
      .Load_Valid(Load_Valid), .Load_Data(Load_Data),
      .Load_Last(Load_Last), .Load_Busy(Load_Busy),
      .Load_Count(Load_Count)
   );

   always #5 Clk = ~Clk;

   // Behavioural model
   logic [31:0] mm [D];
   bit          m_load;
   int          m_ptr, m_cnt;
   logic [31:0] m_ins;
   bit          m_val, m_fm, m_fr;

   task automatic model();
      longint unsigned idx;
      if (Reset) begin
         m_load = 0; m_ptr = 0; m_cnt = 0;
         m_ins = 0; m_val = 0; m_fm = 0; m_fr = 0;
      end else if (m_load) begin
         m_ins = 0; m_val = 0; m_fm = 0; m_fr = 0;
         if (Load_Valid) begin
            mm[m_ptr] = Load_Data;
            m_ptr = (m_ptr + 1) % D;
            m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
            if (Load_Last) m_load = 0;
         end
      end else if (Flush_IF) begin
         m_ins = 0; m_val = 0; m_fm = 0; m_fr = 0;
      end else if (Stall_IF) begin
         m_val = m_val;
      end else if (Load_Start) begin
         m_load = 1; m_ptr = int'(Load_Base); m_cnt = 0;
         m_ins = 0; m_val = 0; m_fm = 0; m_fr = 0;
      end else if (Fetch_En) begin
         idx = longint'(PC_IF) / 4;
         m_fm = (PC_IF % 4) != 0;
         m_fr = idx >= D;
         m_val = 1;
         m_ins = (m_fm || m_fr) ? 32'h0 : mm[idx];
      end else begin
         m_val = 0; m_fm = 0; m_fr = 0;
      end
   endtask

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      model();
      #1;
      tests++;
      if ({Instruction_IF, Valid_IF, Fault_Misaligned, Fault_Range,
           Load_Busy, Load_Count} !==
          {m_ins, m_val, m_fm, m_fr, m_load, 11'(m_cnt)}) begin
         fails++;
         $display("FAIL cycle@%0t: got ins=%h v=%b fm=%b fr=%b busy=%b cnt=%0d expected ins=%h v=%b fm=%b fr=%b busy=%b cnt=%0d",
                  $time, Instruction_IF, Valid_IF, Fault_Misaligned,
                  Fault_Range, Load_Busy, Load_Count, m_ins, m_val,
                  m_fm, m_fr, m_load, m_cnt);
      end
   endtask

   task automatic idle();
      Reset = 0; PC_IF = 0; Fetch_En = 0; Stall_IF = 0; Flush_IF = 0;
      Load_Start = 0; Load_Base = 0; Load_Valid = 0;
      Load_Data = 0; Load_Last = 0;
   endtask

   task automatic fetch(logic [31:0] pc);
      idle(); Fetch_En = 1; PC_IF = pc; step();
   endtask

   task automatic beat(logic [31:0] d, bit last);
      idle(); Load_Valid = 1; Load_Data = d; Load_Last = last; step();
   endtask

   initial begin
      idle();
      Reset = 1;
      step(); step();
      chk("reset_out", {Instruction_IF, Valid_IF, Fault_Misaligned,
                        Fault_Range, Load_Busy}, 64'h0);
      chk("reset_cnt", Load_Count, 0);

      // Program words 0..15
      idle(); Load_Start = 1; Load_Base = 0; step();
      chk("start_busy", Load_Busy, 1);
      for (int i = 0; i < 16; i++)
         beat((i < 4) ? 32'h2008_0001 + i : 32'h100 + i, i == 15);
      chk("load16_cnt", Load_Count, 16);
      chk("load16_busy", Load_Busy, 0);

      // Back-to-back fetches
      fetch(0);  chk("f0", Instruction_IF, 32'h2008_0001);
      fetch(4);  chk("f4", Instruction_IF, 32'h2008_0002);
      fetch(8);  chk("f8", Instruction_IF, 32'h2008_0003);
      fetch(12); chk("f12", {Instruction_IF, Valid_IF, Fault_Misaligned,
                             Fault_Range}, {32'h2008_0004, 3'b100});

      // Stall holds, then samples the current PC
      fetch(4);
      for (int i = 0; i < 3; i++) begin
         idle(); Fetch_En = 1; PC_IF = 8; Stall_IF = 1; step();
         chk("stall_hold", {Instruction_IF, Valid_IF},
             {32'h2008_0002, 1'b1});
      end
      fetch(8); chk("after_stall", Instruction_IF, 32'h2008_0003);
      idle(); Flush_IF = 1; Fetch_En = 1; PC_IF = 12; step();
      chk("flush", {Instruction_IF, Valid_IF}, 33'h0);
      idle(); step();

      // Faults
      fetch(32'h6);
      chk("misalign", {Instruction_IF, Valid_IF, Fault_Misaligned,
                       Fault_Range}, {32'h0, 3'b110});
      fetch(32'h1000);
      chk("range1024", {Valid_IF, Fault_Misaligned, Fault_Range}, 3'b101);
      fetch(32'hFFFF_FFFC);
      chk("range_top", {Instruction_IF, Valid_IF, Fault_Range},
          {32'h0, 2'b11});
      fetch(32'hFFC); chk("idx1023_ok", Fault_Range, 0);

      // Wrapping load session
      idle(); Load_Start = 1; Load_Base = 10'd1022; step();
      beat(32'hA, 0); beat(32'hB, 0); beat(32'hC, 0); beat(32'hD, 1);
      chk("wrap_cnt", Load_Count, 4);
      chk("wrap_busy", Load_Busy, 0);
      fetch(0);      chk("wrap_w0", Instruction_IF, 32'hC);
      fetch(4);      chk("wrap_w1", Instruction_IF, 32'hD);
      fetch(32'hFF8); chk("wrap_w1022", Instruction_IF, 32'hA);
      fetch(32'hFFC); chk("wrap_w1023", Instruction_IF, 32'hB);

      // Reset in the middle of a session
      idle(); Load_Start = 1; Load_Base = 10'd10; step();
      beat(32'h55, 0); beat(32'h66, 0);
      idle(); Reset = 1; step();
      chk("rst_mid_busy", Load_Busy, 0);
      chk("rst_mid_cnt", Load_Count, 0);
      fetch(40); chk("rm10", Instruction_IF, 32'h55);
      fetch(44); chk("rm11", Instruction_IF, 32'h66);
      fetch(48); chk("rm12", Instruction_IF, 32'h10C);
      fetch(52); chk("rm13", Instruction_IF, 32'h10D);
      fetch(56); chk("rm14", Instruction_IF, 32'h10E);

      // Load_Start beats Fetch_En; fetches ignored during LOAD
      idle(); Load_Start = 1; Load_Base = 10'd100;
      Fetch_En = 1; PC_IF = 8; step();
      chk("start_drop", {Valid_IF, Load_Busy}, 2'b01);
      idle(); Fetch_En = 1; PC_IF = 8; Stall_IF = 1; step();
      chk("load_nofetch", Valid_IF, 0);
      idle(); Fetch_En = 1; PC_IF = 8; Load_Valid = 1;
      Load_Data = 32'h77; Load_Last = 1; step();
      chk("one_beat", {Load_Busy, Load_Count}, {1'b0, 11'd1});
      fetch(400); chk("w100", Instruction_IF, 32'h77);

      // Flush together with stall yields a NOP
      fetch(8);
      idle(); Stall_IF = 1; Flush_IF = 1; step();
      chk("flush_stall", {Instruction_IF, Valid_IF}, 33'h0);
      idle(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
